qsys_p01_key_input: RTL and testbench



---
 rtl/qsys_p01_pio_pkg.sv | 26 ++
 rtl/qsys_p01_debounce.sv | 44 ++++
 rtl/qsys_p01_key_input.sv | 117 +++++++++++
 tb/tb_qsys_p01_key_input.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsys_p01_pio_pkg.sv
// Shared definitions for the Qsys PIO slaves (key input and LED output ports):
// register word addresses, edge-type selection and the edge-detect helper.
package qsys_p01_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  function automatic logic [31:0] edge_detect(input edge_type_e et,
                                              input logic [31:0] cur,
                                              input logic [31:0] prv);
    case (et)
      EDGE_RISE: return cur & ~prv;
      EDGE_FALL: return ~cur & prv;
      default:   return cur ^ prv;
    endcase
  endfunction

endpackage

// File: rtl/qsys_p01_debounce.sv
// Single-bit debouncer fed from an already-synchronised input: the output only
// follows the input after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module qsys_p01_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_BIT        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic state_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (sync_in == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      state_d = sync_in;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= IDLE_BIT;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state_out = state_q;

endmodule

// File: rtl/qsys_p01_key_input.sv
// Avalon-MM parallel input port with sticky edge capture and masked level irq.
// Define KEY_INPUT_DEBOUNCE_EN to insert a per-bit debouncer after the synchroniser.
module qsys_p01_key_input
  import qsys_p01_pio_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 2,
  parameter bit IDLE_LEVEL      = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};
  localparam edge_type_e       EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_det, clr;
  logic [31:0]      readdata_q, readdata_d;
  logic [31:0]      state_ext, prev_ext, mask_ext, edge_ext, det_ext;
  logic             wr_en, rd_en;
  logic             unused_bits;

  assign sync1_d = in_port;
  assign sync2_d = sync1_q;

`ifdef KEY_INPUT_DEBOUNCE_EN
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
    qsys_p01_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_BIT       (IDLE_LEVEL)
    ) u_db (
      .clk      (clk),
      .reset    (reset),
      .sync_in  (sync2_q[gi]),
      .state_out(state[gi])
    );
  end
`else
  assign state = sync2_q;
`endif

  always_comb begin
    state_ext = '0;
    prev_ext  = '0;
    mask_ext  = '0;
    edge_ext  = '0;
    state_ext[WIDTH-1:0] = state;
    prev_ext[WIDTH-1:0]  = prev_q;
    mask_ext[WIDTH-1:0]  = mask_q;
    edge_ext[WIDTH-1:0]  = edge_q;
  end

  assign det_ext  = edge_detect(EDGE_SEL, state_ext, prev_ext);
  assign edge_det = det_ext[WIDTH-1:0];
  assign prev_d   = state;
  assign wr_en    = chipselect & ~write_n;
  assign rd_en    = chipselect & ~read_n;

  // A fresh edge is ORed in after the clear so a colliding edge is never lost.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGE) clr = writedata[WIDTH-1:0];
    edge_d = (edge_q & ~clr) | edge_det;
  end

  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      case (address)
        ADDR_DATA: readdata_d = state_ext;
        ADDR_MASK: readdata_d = mask_ext;
        ADDR_EDGE: readdata_d = edge_ext;
        default:   readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= IDLE_VEC;
      sync2_q    <= IDLE_VEC;
      prev_q     <= IDLE_VEC;
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_q & mask_q);

  assign unused_bits = ^{writedata, det_ext, DEBOUNCE_CYCLES != 0};

endmodule

// File: tb/tb_qsys_p01_key_input.sv
// Self-checking bench for qsys_p01_key_input: an any-edge instance checked every
// cycle against a history-based model, plus a falling-edge instance with literal checks.
module tb_qsys_p01_key_input;

  localparam int DB = 4;
`ifdef KEY_INPUT_DEBOUNCE_EN
  localparam bit DB_EN  = 1'b1;
  localparam int ST_LAT = 2 + DB;
`else
  localparam bit DB_EN  = 1'b0;
  localparam int ST_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [17:0] in_port1 = 18'h3FFFF;
  logic [1:0]  addr1 = 2'd0;
  logic        cs1 = 1'b0, rdn1 = 1'b1, wrn1 = 1'b1;
  logic [31:0] wd1 = 32'd0;
  logic [31:0] rd1;
  logic        irq1;

  logic [17:0] in_port2 = 18'h0;
  logic [1:0]  addr2 = 2'd0;
  logic        cs2 = 1'b0, rdn2 = 1'b1, wrn2 = 1'b1;
  logic [31:0] wd2 = 32'd0;
  logic [31:0] rd2;
  logic        irq2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  qsys_p01_key_input #(
    .WIDTH(18), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(2), .IDLE_LEVEL(1'b0)
  ) dut_any (
    .clk(clk), .reset(reset), .in_port(in_port1), .address(addr1),
    .chipselect(cs1), .read_n(rdn1), .write_n(wrn1), .writedata(wd1),
    .readdata(rd1), .irq(irq1)
  );

  qsys_p01_key_input #(
    .WIDTH(18), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(1), .IDLE_LEVEL(1'b0)
  ) dut_fall (
    .clk(clk), .reset(reset), .in_port(in_port2), .address(addr2),
    .chipselect(cs2), .read_n(rdn2), .write_n(wrn2), .writedata(wd2),
    .readdata(rd2), .irq(irq2)
  );

  // Model: sample history of in_port and state history; a debounced bit flips
  // once the last DB synchronised samples all disagree with it.
  logic [17:0] smp[$];
  logic [17:0] sth[$];
  logic [17:0] m_edge, m_mask;
  logic [31:0] m_rd;
  logic        m_irq;
  bit          model_ready = 1'b0;

  always @(posedge clk) begin : model
    logic [17:0] cur, nxt, det, clrv;
    bit flip;
    if (reset) begin
      smp.delete();
      sth.delete();
      for (int i = 0; i < DB + 2; i++) smp.push_back(18'h0);
      sth.push_back(18'h0);
      sth.push_back(18'h0);
      m_edge = '0;
      m_mask = '0;
      m_rd   = '0;
      m_irq  = 1'b0;
      model_ready = 1'b1;
    end else begin
      smp.push_front(in_port1);
      void'(smp.pop_back());
      cur = sth[0];
      if (DB_EN) begin
        for (int b = 0; b < 18; b++) begin
          flip = 1'b1;
          for (int j = 2; j < DB + 2; j++)
            if (smp[j][b] == cur[b]) flip = 1'b0;
          nxt[b] = flip ? ~cur[b] : cur[b];
        end
      end else begin
        nxt = smp[1];
      end
      det = sth[0] ^ sth[1];
      if (cs1 && !rdn1) begin
        case (addr1)
          2'd0:    m_rd = {14'h0, sth[0]};
          2'd2:    m_rd = {14'h0, m_mask};
          2'd3:    m_rd = {14'h0, m_edge};
          default: m_rd = 32'h0;
        endcase
      end
      clrv = '0;
      if (cs1 && !wrn1) begin
        if (addr1 == 2'd2) m_mask = wd1[17:0];
        if (addr1 == 2'd3) clrv = wd1[17:0];
      end
      m_edge = (m_edge & ~clrv) | det;
      sth.push_front(nxt);
      void'(sth.pop_back());
      m_irq = |(m_edge & m_mask);
    end
  end

  always @(negedge clk) begin
    if (!reset && model_ready) begin
      tests++;
      if (rd1 !== m_rd || irq1 !== m_irq) begin
        fails++;
        $display("FAIL model_cycle t=%0t: readdata=0x%08h irq=%0b expected readdata=0x%08h irq=%0b",
                 $time, rd1, irq1, m_rd, m_irq);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      $display("[TB] %s ok: 0x%08h", nm, act);
    end
  endtask

  task automatic bus_wr(input int d, input logic [1:0] a, input logic [31:0] v);
    if (d == 1) begin cs1 = 1'b1; wrn1 = 1'b0; addr1 = a; wd1 = v; end
    else        begin cs2 = 1'b1; wrn2 = 1'b0; addr2 = a; wd2 = v; end
    @(negedge clk);
    cs1 = 1'b0; wrn1 = 1'b1; cs2 = 1'b0; wrn2 = 1'b1;
    $display("[TB] write dut%0d addr=%0d data=0x%08h", d, a, v);
  endtask

  task automatic bus_rd(input int d, input logic [1:0] a, output logic [31:0] v);
    if (d == 1) begin cs1 = 1'b1; rdn1 = 1'b0; addr1 = a; end
    else        begin cs2 = 1'b1; rdn2 = 1'b0; addr2 = a; end
    @(negedge clk);
    v = (d == 1) ? rd1 : rd2;
    cs1 = 1'b0; rdn1 = 1'b1; cs2 = 1'b0; rdn2 = 1'b1;
    $display("[TB] read dut%0d addr=%0d data=0x%08h", d, a, v);
  endtask

  initial begin
    logic [31:0] v;

    // Reset held with all inputs high; nothing captured at release.
    repeat (3) @(negedge clk);
    chk("reset_readdata", rd1, 32'h0);
    chk("reset_irq", {31'h0, irq1}, 32'h0);
    reset = 1'b0;
    bus_rd(1, 2'd3, v);
    chk("edge_after_release", v, 32'h0);
    repeat (12) @(negedge clk);
    in_port1 = 18'h0;
    repeat (12) @(negedge clk);
    bus_wr(1, 2'd3, 32'h3FFFF);
    bus_rd(1, 2'd3, v);
    chk("edge_cleared", v, 32'h0);

    // Clean rising edge on bit 0.
    bus_wr(1, 2'd2, 32'h1);
    in_port1[0] = 1'b1;
    repeat (ST_LAT) @(negedge clk);
    chk("irq_before_capture", {31'h0, irq1}, 32'h0);
    @(negedge clk);
    chk("irq_at_capture", {31'h0, irq1}, 32'h1);
    bus_rd(1, 2'd0, v);
    chk("clean_data", v, 32'h1);
    bus_rd(1, 2'd3, v);
    chk("clean_edge", v, 32'h1);
    bus_wr(1, 2'd3, 32'h1);
    chk("irq_after_clear", {31'h0, irq1}, 32'h0);

    // Bounce on bit 3: two-cycle pulses never survive the debouncer.
    for (int i = 0; i < 10; i++) begin
      in_port1[3] = ~in_port1[3];
      repeat (2) @(negedge clk);
    end
    in_port1[3] = 1'b0;
    repeat (12) @(negedge clk);
    bus_rd(1, 2'd0, v);
    chk("bounce_data", v, 32'h1);
    bus_rd(1, 2'd3, v);
    chk("bounce_edge", v, DB_EN ? 32'h0 : 32'h8);
    bus_wr(1, 2'd3, 32'h8);

    // Masked edge on bit 5.
    bus_wr(1, 2'd2, 32'h0);
    in_port1[5] = 1'b1;
    repeat (ST_LAT + 3) @(negedge clk);
    bus_rd(1, 2'd3, v);
    chk("mask_edge", v, 32'h20);
    chk("mask_irq_off", {31'h0, irq1}, 32'h0);
    bus_wr(1, 2'd2, 32'h20);
    chk("mask_irq_on", {31'h0, irq1}, 32'h1);
    bus_wr(1, 2'd3, 32'h20);
    chk("mask_irq_cleared", {31'h0, irq1}, 32'h0);

    // Clear of bit 2 collides with a new falling edge on bit 2.
    bus_wr(1, 2'd2, 32'h4);
    in_port1[2] = 1'b1;
    repeat (ST_LAT + 3) @(negedge clk);
    chk("coll_irq_pre", {31'h0, irq1}, 32'h1);
    in_port1[2] = 1'b0;
    repeat (ST_LAT) @(negedge clk);
    bus_wr(1, 2'd3, 32'h4);
    chk("coll_irq_kept", {31'h0, irq1}, 32'h1);
    bus_rd(1, 2'd3, v);
    chk("coll_edge_kept", v, 32'h4);
    bus_wr(1, 2'd3, 32'h4);
    chk("coll_irq_cleared", {31'h0, irq1}, 32'h0);

    // Falling-only instance: the rise is ignored, the fall is captured.
    bus_wr(2, 2'd2, 32'h2);
    in_port2[1] = 1'b1;
    repeat (ST_LAT + 4) @(negedge clk);
    bus_rd(2, 2'd3, v);
    chk("fall_rise_ignored", v, 32'h0);
    bus_rd(2, 2'd0, v);
    chk("fall_data_high", v, 32'h2);
    in_port2[1] = 1'b0;
    repeat (ST_LAT) @(negedge clk);
    chk("fall_irq_before", {31'h0, irq2}, 32'h0);
    @(negedge clk);
    chk("fall_irq_at", {31'h0, irq2}, 32'h1);
    bus_rd(2, 2'd3, v);
    chk("fall_edge", v, 32'h2);

    // Reserved address reads zero and ignores writes.
    bus_wr(1, 2'd1, 32'hFFFFFFFF);
    bus_rd(1, 2'd1, v);
    chk("rsvd_read", v, 32'h0);

    // Reset during a held read and during a partial debounce.
    in_port1 = 18'h00200;
    repeat (ST_LAT + 3) @(negedge clk);
    bus_rd(1, 2'd0, v);
    chk("pre_reset_data", v, 32'h200);
    in_port1[7] = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midread_reset", rd1, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (ST_LAT + 4) @(negedge clk);
    bus_rd(1, 2'd0, v);
    chk("post_reset_data", v, 32'h280);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
